// File: rtl/arm_mem_pkg.sv
// Shared memory-system definitions: bus widths, word addresses, store-buffer entries.
package arm_mem_pkg;

    // Byte-address and data widths of the core's data port.
    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;

    // Default store-buffer depth, also used by the dmem wrappers.
    localparam int SB_DEPTH = 4;

    // Word address. The two byte-offset bits are dropped because every access
    // is word-aligned.
    typedef logic [MEM_AW-1:2] word_adr_t;

    // One posted store.
    typedef struct packed {
        logic [MEM_AW-1:0] adr;
        logic [MEM_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding lookup. It finds the youngest valid buffered store
// whose word address matches the load address.
module sb_fwd_match
    import arm_mem_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    localparam int PW    = $clog2(DEPTH)
) (
    input  word_adr_t         ent_wadr [DEPTH],
    input  logic [MEM_DW-1:0] ent_data [DEPTH],
    input  logic [DEPTH-1:0]  valid,
    input  logic [PW-1:0]     head,
    input  logic [PW-1:0]     tail,
    input  word_adr_t         lookup,
    output logic              hit,
    output logic [MEM_DW-1:0] hit_data
);

    logic [PW-1:0] idx;
    logic          scan;

    // Walk from the youngest entry (tail-1) back to the oldest (head). The
    // first match found wins.
    always_comb begin
        // NOTE: every output and temporary gets a default before any conditional
        // assignment. Without the defaults, always_comb would infer a latch.
        hit      = 1'b0;
        hit_data = '0;
        scan     = 1'b1;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail - PW'(k + 1);
            if (scan && !hit && valid[idx] && (ent_wadr[idx] == lookup)) begin
                hit      = 1'b1;
                hit_data = ent_data[idx];
            end
            if (idx == head) begin
                scan = 1'b0;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core's data port and a slower data RAM.
// Stores retire into the buffer in one cycle and drain to the RAM in order.
// Loads read the RAM combinationally and are overridden by the youngest
// buffered store to the same word.
module store_buffer
    import arm_mem_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    localparam int AW    = MEM_AW,
    localparam int DW    = MEM_DW,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    // core side
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wd,
    output logic [DW-1:0] cpu_rd,
    output logic          cpu_stall,
    // RAM read port
    output logic [AW-1:0] mem_radr,
    input  logic [DW-1:0] mem_rd,
    // RAM write port
    output logic          mem_wvalid,
    input  logic          mem_wready,
    output logic [AW-1:0] mem_wadr,
    output logic [DW-1:0] mem_wd,
    // status
    output logic          sb_empty,
    output logic [CW-1:0] sb_count
);

    sb_entry_t         entries [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    word_adr_t         ent_wadr [DEPTH];
    logic [DW-1:0]     ent_data [DEPTH];
    logic              fwd_hit;
    logic [DW-1:0]     fwd_data;

    // A full buffer rejects the store outright, even if the head drains in the
    // same cycle. The core simply re-presents the store on the next cycle.
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push      = cpu_we & ~full;
    assign pop       = mem_wvalid & mem_wready;
    assign cpu_stall = cpu_we & full;

    // Write port follows the count register, so a reset drops it without
    // waiting for a clock edge.
    assign mem_wvalid = ~empty;
    assign mem_wadr   = entries[head].adr;
    assign mem_wd     = entries[head].data;
    assign sb_empty   = empty;
    assign sb_count   = count;
    assign mem_radr   = cpu_adr;

    // Pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments. Every register then
        // sees the values from before the edge, whatever the statement order.
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                tail        <= tail + 1'b1;
                valid[tail] <= 1'b1;
            end
            if (pop) begin
                head        <= head + 1'b1;
                valid[head] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage is written only on an accepted store.
    always_ff @(posedge clk) begin
        // NOTE: the payload array has no reset. The valid bits and count already
        // mark stale contents, so a reset term would only add muxes to a RAM-like array.
        if (push) begin
            entries[tail] <= '{adr: cpu_adr, data: cpu_wd};
        end
    end

    // Present word addresses and data to the forwarding search.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_wadr[i] = entries[i].adr[AW-1:2];
            ent_data[i] = entries[i].data;
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .ent_wadr (ent_wadr),
        .ent_data (ent_data),
        .valid    (valid),
        .head     (head),
        .tail     (tail),
        .lookup   (cpu_adr[AW-1:2]),
        .hit      (fwd_hit),
        .hit_data (fwd_data)
    );

    // Loads take the RAM value unless a buffered store to the same word is
    // still pending.
    assign cpu_rd = fwd_hit ? fwd_data : mem_rd;

endmodule
